// File: rtl/fmul_pkg.sv
// Shared FMUL32 definitions: opcode encoding and default pipeline latency.
package fmul_pkg;

    typedef enum logic [1:0] {
        OPC_MUL   = 2'd0,
        OPC_INV_S = 2'd1,
        OPC_ABS_W = 2'd2,
        OPC_IDLE  = 2'd3
    } fmul_opc_e;

    localparam int FMUL_OPC_NUM  = 4;
    localparam int FMUL_PIPE_LAT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active requester after ptr_i, wrapping at N-1.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the search, so no path can infer a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmul_scheduler.sv
// Shares one fixed-latency FMUL32 pipeline between REQ_NUM requesters; results return
// in issue order, tagged with the owner ID carried alongside the multiplier pipeline.
module fmul_scheduler
    import fmul_pkg::*;
#(
    parameter int  REQ_NUM       = 4,
    parameter int  DATA_W        = 32,
    parameter int  OPERATION_NUM = FMUL_OPC_NUM,
    parameter int  PIPE_LAT      = FMUL_PIPE_LAT,
    localparam int OPC_W         = $clog2(OPERATION_NUM),
    localparam int ID_W          = $clog2(REQ_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQ_NUM-1:0]         req_valid,
    input  logic [REQ_NUM*DATA_W-1:0]  req_op1,
    input  logic [REQ_NUM*DATA_W-1:0]  req_op2,
    input  logic [REQ_NUM*OPC_W-1:0]   req_opc,
    output logic [REQ_NUM-1:0]         req_ready,
    input  logic                       sched_en,
    output logic [DATA_W-1:0]          fmul_op1,
    output logic [DATA_W-1:0]          fmul_op2,
    output logic [OPC_W-1:0]           fmul_opc,
    output logic                       fmul_issue,
    input  logic [DATA_W-1:0]          fmul_result,
    input  logic                       fmul_val,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       busy,
    output logic                       err
);

    logic [REQ_NUM-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                accept;

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic                issue_q, issue_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [ID_W-1:0]     id_q, id_d;

    logic [PIPE_LAT-1:0] tag_vld_q;
    logic [ID_W-1:0]     tag_id_q [PIPE_LAT];
    logic                tag_out_vld;
    logic [ID_W-1:0]     tag_out_id;

    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                err_q, err_d;

    rr_arbiter #(
        .N     (REQ_NUM),
        .IDX_W (ID_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign accept    = sched_en & grant_any;
    assign req_ready = sched_en ? grant : '0;

    always_comb begin
        ptr_d   = ptr_q;
        issue_d = accept;
        op1_d   = op1_q;
        op2_d   = op2_q;
        opc_d   = opc_q;
        id_d    = id_q;
        if (accept) begin
            ptr_d = grant_idx;
            op1_d = req_op1[int'(grant_idx)*DATA_W +: DATA_W];
            op2_d = req_op2[int'(grant_idx)*DATA_W +: DATA_W];
            opc_d = req_opc[int'(grant_idx)*OPC_W +: OPC_W];
            id_d  = grant_idx;
        end
    end

    // The tag pipe mirrors FMUL32 stage for stage and is the sole source of response timing.
    assign tag_out_vld = tag_vld_q[PIPE_LAT-1];
    assign tag_out_id  = tag_id_q[PIPE_LAT-1];

    always_comb begin
        rsp_id_d   = tag_out_vld ? tag_out_id  : rsp_id_q;
        rsp_data_d = tag_out_vld ? fmul_result : rsp_data_q;
        err_d      = err_q | (fmul_val ^ tag_out_vld);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= ID_W'(REQ_NUM - 1);
            issue_q     <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            opc_q       <= '0;
            id_q        <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            issue_q      <= issue_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            opc_q        <= opc_d;
            id_q         <= id_d;
            tag_vld_q[0] <= issue_q;
            for (int s = 1; s < PIPE_LAT; s++) tag_vld_q[s] <= tag_vld_q[s-1];
            rsp_valid_q  <= tag_out_vld;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
        end
    end

    // NOTE: the ID array is not reset; an entry is only ever read when its valid bit is set.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= id_q;
        for (int s = 1; s < PIPE_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
    end

    assign fmul_issue = issue_q;
    assign fmul_op1   = op1_q;
    assign fmul_op2   = op2_q;
    assign fmul_opc   = opc_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign err        = err_q;
    assign busy       = issue_q | (|tag_vld_q) | rsp_valid_q;

endmodule

// File: doc/fmul_scheduler.md
FMUL_SCHEDULER -- requirements
Module: fmul_scheduler

Interface
REQ-001 Parameter REQ_NUM, default 4: number of requesters sharing one FMUL32 pipeline (2..8).
REQ-002 Parameter DATA_W, default 32: operand/result width.
REQ-003 Parameter OPERATION_NUM, default 4: opcode count; opc width is $clog2(OPERATION_NUM).
REQ-004 Parameter PIPE_LAT, default 2: FMUL32 latency in cycles, from fmul_issue to fmul_val (1..8).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  REQ_NUM  per-requester request strobe.
REQ-008 req_op1, req_op2  input  REQ_NUM*DATA_W each  packed operands; slice i belongs to requester i.
REQ-009 req_opc  input  REQ_NUM*$clog2(OPERATION_NUM)  packed opcodes.
REQ-010 req_ready  output  REQ_NUM  one-hot-or-zero accept; a transfer occurs when req_valid[i] & req_ready[i] are both high at a clock edge.
REQ-011 sched_en  input  1  0 blocks new grants; in-flight operations still drain.
REQ-012 fmul_op1, fmul_op2  output  DATA_W  registered operands to FMUL32.
REQ-013 fmul_opc  output  $clog2(OPERATION_NUM)  registered opcode to FMUL32.
REQ-014 fmul_issue  output  1  high for one cycle per issued operation.
REQ-015 fmul_result  input  DATA_W  FMUL32 result; fmul_val  input  1  FMUL32 result valid.
REQ-016 rsp_valid  output  1  registered response strobe; rsp_id  output  $clog2(REQ_NUM)  owner; rsp_data  output  DATA_W  result. No response backpressure.
REQ-017 busy  output  1  high while any operation is in issue register, tag pipe or response register.
REQ-018 err  output  1  sticky latency-mismatch flag.

Function
REQ-019 Arbitration SHALL be round-robin: the search starts at the requester after the last granted one, wrapping from REQ_NUM-1 to 0; at most one grant per cycle.
REQ-020 req_ready SHALL be combinational from req_valid, the RR pointer and sched_en; req_ready SHALL be all-zero when sched_en=0.
REQ-021 A requester holding req_valid SHALL be granted within REQ_NUM cycles while sched_en=1 (no starvation).
REQ-022 On acceptance at edge E0, operands, opcode and requester ID SHALL be captured; fmul_issue=1 in the cycle after E0; the RR pointer updates to the granted index at E0.
REQ-023 Back-to-back issue SHALL be supported: a new acceptance every cycle, throughput 1 op/cycle.
REQ-024 The requester ID SHALL travel in a PIPE_LAT-deep valid+ID tag shift register aligned with FMUL32.
REQ-025 When the tag pipe output is valid, rsp_valid=1, rsp_id=tag ID and rsp_data=fmul_result SHALL be registered; the response is visible PIPE_LAT+1 cycles after E0.
REQ-026 Responses SHALL leave in issue order; rsp_data is don't-care when rsp_valid=0 but SHALL hold its last value.
REQ-027 If fmul_val differs from the tag pipe output valid in any cycle, err SHALL set and remain set until reset; rsp behaviour is unchanged (tag pipe is authoritative).
REQ-028 Deasserting sched_en mid-stream SHALL not drop or reorder in-flight operations; busy falls one cycle after the last rsp_valid.
REQ-029 The opcode SHALL pass through unmodified; IDLE opcodes are issued and returned like any other.

Reset
REQ-030 On rst_n=0, asynchronously: fmul_issue=0, rsp_valid=0, all tag valids=0, err=0, busy=0, RR pointer=REQ_NUM-1 (requester 0 highest priority first), fmul_op1/op2/opc=0, rsp_id=0, rsp_data=0.
REQ-031 Reset mid-operation SHALL discard all in-flight operations; no response for them follows reset release.

Structure
REQ-032 Opcode encoding constants (MUL=0, INV_S=1, ABS_W=2, IDLE=3) and default PIPE_LAT SHALL live in the shared fmul_pkg package, also used by FMUL32.
REQ-033 Round-robin logic SHALL be one sub-module, rr_arbiter (req, pointer -> one-hot grant, index); the tag pipe and response register stay in fmul_scheduler.

Verification
REQ-034 Single request: req0 op1=0x3FC00000, op2=0x40000000, opc=MUL at E0 -> fmul_issue at E0+1; rsp_valid, rsp_id=0, rsp_data=0x40400000 at E0+3 (PIPE_LAT=2, fixed-latency multiplier model).
REQ-035 All four req_valid held high 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; 8 responses with ids 0,1,2,3,0,1,2,3 on consecutive cycles.
REQ-036 req1 and req3 continuously valid, sched_en toggled 0 for cycles 3-5 -> no req_ready during 3-5; alternating 1,3 resumes; busy drops after last response.
REQ-037 Model delays fmul_val by one cycle once -> err=1 sticky until rst_n pulse; responses still follow tag timing.
REQ-038 rst_n asserted with 3 ops in flight -> all outputs at reset values immediately; no rsp_valid after release until new acceptance.
REQ-039 Sweep PIPE_LAT=1 and 8 with random traffic -> scoreboard: every accepted op answered exactly once, in order, at E0+PIPE_LAT+1.
